// File: rtl/cascade_counter_pkg.sv
// rtl/cascade_counter_pkg.sv - shared types, limits and load clamping for cascade_counter
package cascade_counter_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_STEP
    } cnt_op_e;

    localparam int MAX_DIGITS  = 8;
    localparam int MAX_MODULUS = 16;
    localparam int MAX_DW      = $clog2(MAX_MODULUS);

    // Load fields can exceed the digit range; saturate them to the top digit value.
    function automatic logic [MAX_DW-1:0] clamp_digit(input logic [MAX_DW-1:0] field,
                                                      input int unsigned       modulus);
        if (32'(field) >= modulus) begin
            return MAX_DW'(modulus - 1);
        end
        return field;
    endfunction

endpackage

// File: rtl/cascade_counter_digit.sv
// rtl/cascade_counter_digit.sv - one modulo-MODULUS digit slice with terminal/wrap detect
// Down counting is elaborated only with CASCADE_COUNTER_UPDOWN_EN defined.
module counter_digit
    import cascade_counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DW      = $clog2(MODULUS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  cnt_op_e       op,
    input  logic          step_en,
`ifdef CASCADE_COUNTER_UPDOWN_EN
    input  logic          up,
`endif
    input  logic [DW-1:0] load_field,
    output logic [DW-1:0] digit_o,
    output logic          is_terminal,
    output logic          wraps_next
);

    localparam logic [DW-1:0] LAST = DW'(MODULUS - 1);

    logic [DW-1:0] digit_d, digit_q;
    logic [DW-1:0] next_val;

    always_comb begin
`ifdef CASCADE_COUNTER_UPDOWN_EN
        if (up) begin
            next_val    = (digit_q == LAST) ? '0 : digit_q + DW'(1);
            is_terminal = (digit_q == LAST);
        end else begin
            next_val    = (digit_q == '0) ? LAST : digit_q - DW'(1);
            is_terminal = (digit_q == '0);
        end
`else
        next_val    = (digit_q == LAST) ? '0 : digit_q + DW'(1);
        is_terminal = (digit_q == LAST);
`endif
        wraps_next = step_en & is_terminal;
    end

    always_comb begin
        digit_d = digit_q;
        unique case (op)
            OP_CLR:  digit_d = '0;
            OP_LOAD: digit_d = DW'(clamp_digit(MAX_DW'(load_field), MODULUS));
            OP_STEP: if (step_en) digit_d = next_val;
            default: digit_d = digit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/cascade_counter.sv
// rtl/cascade_counter.sv - cascadable multi-digit modulo counter with load, clear and ripple carry
// Optional up/down direction input enabled by CASCADE_COUNTER_UPDOWN_EN.
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter  int DIGITS  = 2,
    parameter  int MODULUS = 10,
    localparam int DW      = $clog2(MODULUS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [DIGITS*DW-1:0] load_val_i,
    input  logic                 enp_i,
    input  logic                 ent_i,
`ifdef CASCADE_COUNTER_UPDOWN_EN
    input  logic                 up_i,
`endif
    output logic [DIGITS*DW-1:0] count_o,
    output logic                 rco_o,
    output logic                 wrap_o
);

    if (DIGITS < 1 || DIGITS > MAX_DIGITS || MODULUS < 2 || MODULUS > MAX_MODULUS) begin : g_bad_cfg
        $error("cascade_counter: DIGITS or MODULUS out of range");
    end

    cnt_op_e           op;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] wraps;
    logic [DIGITS-1:0] step_en;
    logic              wrap_d, wrap_q;

    always_comb begin
        if (clr_i)                op = OP_CLR;
        else if (load_i)          op = OP_LOAD;
        else if (enp_i && ent_i)  op = OP_STEP;
        else                      op = OP_HOLD;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        // A digit advances only while every lower digit sits at its terminal value.
        if (k == 0) begin : g_lsd
            assign step_en[k] = 1'b1;
        end else begin : g_upper
            assign step_en[k] = &term[k-1:0];
        end

        counter_digit #(
            .MODULUS (MODULUS),
            .DW      (DW)
        ) u_digit (
            .clk         (clk),
            .rst_n       (rst_n),
            .op          (op),
            .step_en     (step_en[k]),
`ifdef CASCADE_COUNTER_UPDOWN_EN
            .up          (up_i),
`endif
            .load_field  (load_val_i[k*DW +: DW]),
            .digit_o     (count_o[k*DW +: DW]),
            .is_terminal (term[k]),
            .wraps_next  (wraps[k])
        );
    end

    assign rco_o  = ent_i & (&term);
    assign wrap_d = (op == OP_STEP) & (&wraps);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_cascade_counter.sv
// tb/tb_cascade_counter.sv - self-checking bench for cascade_counter against a numeric model
module tb_cascade_counter;

    localparam int D   = 2;
    localparam int M   = 10;
    localparam int W   = 8;
    localparam int TOP = 100;

    logic         clk = 1'b0;
    logic         rst_n, clr, load, enp, ent, up_tb;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         rco, wrap;

    logic         c_clr, c_en;
    logic [3:0]   c_lo, c_hi;
    logic         lo_rco, hi_rco, lo_wrap, hi_wrap;

    int           n_pass  = 0;
    int           n_total = 0;
    int           mval    = 0;
    logic         mwrap   = 1'b0;

    always #5 clk = ~clk;

    cascade_counter #(.DIGITS(D), .MODULUS(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .load_i     (load),
        .load_val_i (load_val),
        .enp_i      (enp),
        .ent_i      (ent),
`ifdef CASCADE_COUNTER_UPDOWN_EN
        .up_i       (up_tb),
`endif
        .count_o    (count),
        .rco_o      (rco),
        .wrap_o     (wrap)
    );

    cascade_counter #(.DIGITS(1), .MODULUS(16)) c_lo_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (c_clr),
        .load_i     (1'b0),
        .load_val_i (4'h0),
        .enp_i      (c_en),
        .ent_i      (c_en),
`ifdef CASCADE_COUNTER_UPDOWN_EN
        .up_i       (1'b1),
`endif
        .count_o    (c_lo),
        .rco_o      (lo_rco),
        .wrap_o     (lo_wrap)
    );

    cascade_counter #(.DIGITS(1), .MODULUS(16)) c_hi_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (c_clr),
        .load_i     (1'b0),
        .load_val_i (4'h0),
        .enp_i      (c_en),
        .ent_i      (lo_rco),
`ifdef CASCADE_COUNTER_UPDOWN_EN
        .up_i       (1'b1),
`endif
        .count_o    (c_hi),
        .rco_o      (hi_rco),
        .wrap_o     (hi_wrap)
    );

    function automatic logic [7:0] enc(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int dec_load(input logic [7:0] lv);
        int lo, hi;
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        return hi * 10 + lo;
    endfunction

    function automatic logic exp_rco();
        return ent && (up_tb ? (mval == TOP - 1) : (mval == 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (clr) begin
            mval  = 0;
            mwrap = 1'b0;
        end else if (load) begin
            mval  = dec_load(load_val);
            mwrap = 1'b0;
        end else if (enp && ent) begin
            if (up_tb) begin
                mwrap = (mval == TOP - 1);
                mval  = (mval + 1) % TOP;
            end else begin
                mwrap = (mval == 0);
                mval  = (mval + TOP - 1) % TOP;
            end
        end else begin
            mwrap = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 0; load = 0; enp = 0; ent = 0; up_tb = 1'b1; load_val = '0;
        c_clr = 0; c_en = 0;
        #12;
        n_total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            $display("FAIL reset_initial count=%h wrap=%b expected 00/0", count, wrap);
        end else n_pass++;
        rst_n = 1'b1; mval = 0; mwrap = 1'b0;
        load = 1; load_val = 8'h37;
        tick();
        load = 0;
        n_total++;
        if (count !== 8'h37) begin
            $display("FAIL reset_preload count=%h expected 37", count);
        end else n_pass++;
        enp = 1; ent = 1;
        #3 rst_n = 1'b0;
        #1;
        n_total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            $display("FAIL reset_async count=%h wrap=%b expected 00/0", count, wrap);
        end else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            $display("FAIL reset_held count=%h wrap=%b expected 00/0", count, wrap);
        end else n_pass++;
        rst_n = 1'b1; enp = 0; ent = 0; mval = 0; mwrap = 1'b0;
    endtask

    task automatic test_up_count();
        clr = 1; tick(); clr = 0;
        enp = 1; ent = 1;
        for (int i = 1; i <= 101; i++) begin
            tick();
            n_total++;
            if (count !== enc(mval) || wrap !== mwrap || rco !== exp_rco()) begin
                $display("FAIL up_count edge=%0d count=%h wrap=%b rco=%b expected %h/%b/%b",
                         i, count, wrap, rco, enc(mval), mwrap, exp_rco());
            end else n_pass++;
            if (i == 99) begin
                n_total++;
                if (count !== 8'h99 || rco !== 1'b1) begin
                    $display("FAIL up_terminal count=%h rco=%b expected 99/1", count, rco);
                end else n_pass++;
            end
            if (i == 100) begin
                n_total++;
                if (count !== 8'h00 || wrap !== 1'b1) begin
                    $display("FAIL up_wrap count=%h wrap=%b expected 00/1", count, wrap);
                end else n_pass++;
            end
            if (i == 101) begin
                n_total++;
                if (wrap !== 1'b0) begin
                    $display("FAIL up_wrap_single wrap=%b expected 0", wrap);
                end else n_pass++;
            end
        end
        enp = 0; ent = 0;
    endtask

    task automatic test_enables();
        load = 1; load_val = 8'h99; tick(); load = 0;
        enp = 1; ent = 0;
        #1;
        n_total++;
        if (rco !== 1'b0) begin
            $display("FAIL ent_gates_rco rco=%b expected 0", rco);
        end else n_pass++;
        tick();
        n_total++;
        if (count !== 8'h99 || count !== enc(mval)) begin
            $display("FAIL ent_hold count=%h expected 99", count);
        end else n_pass++;
        enp = 0; ent = 1;
        #1;
        n_total++;
        if (rco !== 1'b1) begin
            $display("FAIL enp_no_rco_gate rco=%b expected 1", rco);
        end else n_pass++;
        tick();
        n_total++;
        if (count !== 8'h99 || wrap !== 1'b0) begin
            $display("FAIL enp_hold count=%h wrap=%b expected 99/0", count, wrap);
        end else n_pass++;
        ent = 0;
    endtask

    task automatic test_priority();
        load = 1; load_val = 8'hC5; tick();
        n_total++;
        if (count !== 8'h95) begin
            $display("FAIL clamp_hi count=%h expected 95", count);
        end else n_pass++;
        load_val = 8'hFA; tick();
        n_total++;
        if (count !== 8'h99) begin
            $display("FAIL clamp_both count=%h expected 99", count);
        end else n_pass++;
        // At terminal with counting enabled, clear must beat both load and the wrap.
        clr = 1; load = 1; load_val = 8'hC5; enp = 1; ent = 1;
        #1;
        n_total++;
        if (rco !== 1'b1) begin
            $display("FAIL rco_ignores_clr rco=%b expected 1", rco);
        end else n_pass++;
        tick();
        n_total++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            $display("FAIL clr_over_load count=%h wrap=%b expected 00/0", count, wrap);
        end else n_pass++;
        clr = 0; load = 0; enp = 0; ent = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 9) == 0);
            enp      = ($urandom_range(0, 3) != 0);
            ent      = ($urandom_range(0, 3) != 0);
            load_val = W'($urandom);
`ifdef CASCADE_COUNTER_UPDOWN_EN
            up_tb    = 1'($urandom_range(0, 1));
`endif
            #1;
            n_total++;
            if (rco !== exp_rco()) begin
                $display("FAIL rand_rco cycle=%0d rco=%b expected %b", i, rco, exp_rco());
            end else n_pass++;
            tick();
            n_total++;
            if (count !== enc(mval) || wrap !== mwrap) begin
                $display("FAIL rand_state cycle=%0d count=%h wrap=%b expected %h/%b",
                         i, count, wrap, enc(mval), mwrap);
            end else n_pass++;
        end
        clr = 0; load = 0; enp = 0; ent = 0; up_tb = 1'b1;
    endtask

    task automatic test_cascade();
        int ref_cnt;
        c_en = 0; c_clr = 1; tick(); c_clr = 0;
        c_en = 1; ref_cnt = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            ref_cnt = (ref_cnt + 1) % 256;
            n_total++;
            if ({c_hi, c_lo} !== 8'(ref_cnt) || lo_rco !== (ref_cnt % 16 == 15) ||
                hi_rco !== (ref_cnt == 255) || lo_wrap !== (ref_cnt % 16 == 0) ||
                hi_wrap !== (ref_cnt == 0)) begin
                $display("FAIL cascade edge=%0d value=%h rco=%b%b wrap=%b%b expected %h",
                         i, {c_hi, c_lo}, hi_rco, lo_rco, hi_wrap, lo_wrap, 8'(ref_cnt));
            end else n_pass++;
        end
        c_en = 0;
    endtask

`ifdef CASCADE_COUNTER_UPDOWN_EN
    task automatic test_updown();
        clr = 1; tick(); clr = 0;
        up_tb = 0; enp = 1; ent = 1;
        #1;
        n_total++;
        if (rco !== 1'b1) begin
            $display("FAIL down_rco_at_zero rco=%b expected 1", rco);
        end else n_pass++;
        tick();
        n_total++;
        if (count !== 8'h99 || wrap !== 1'b1) begin
            $display("FAIL down_wrap count=%h wrap=%b expected 99/1", count, wrap);
        end else n_pass++;
        load = 1; load_val = 8'h50; tick(); load = 0;
        tick();
        n_total++;
        if (count !== 8'h49) begin
            $display("FAIL down_step count=%h expected 49", count);
        end else n_pass++;
        load = 1; tick(); load = 0;
        up_tb = 1;
        tick();
        n_total++;
        if (count !== 8'h51 || count !== enc(mval)) begin
            $display("FAIL dir_same_edge count=%h expected 51", count);
        end else n_pass++;
        enp = 0; ent = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_enables();
        test_priority();
        test_random();
        test_cascade();
`ifdef CASCADE_COUNTER_UPDOWN_EN
        test_updown();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
